// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result-commit path: opcodes, classes, fields, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

    // Instruction field positions
    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 26;
    localparam int RDST_MSB = 25;
    localparam int RDST_LSB = 21;

    // The 16 defined opcodes; everything from 6'b010000 upward is illegal
    localparam logic [5:0] OP_MOV = 6'b000000;
    localparam logic [5:0] OP_LD  = 6'b000001;
    localparam logic [5:0] OP_ST  = 6'b000010;
    localparam logic [5:0] OP_XFR = 6'b000011;
    localparam logic [5:0] OP_ADD = 6'b000100;
    localparam logic [5:0] OP_SUB = 6'b000101;
    localparam logic [5:0] OP_AND = 6'b000110;
    localparam logic [5:0] OP_MUL = 6'b000111;
    localparam logic [5:0] OP_DIV = 6'b001000;
    localparam logic [5:0] OP_OR  = 6'b001001;
    localparam logic [5:0] OP_XOR = 6'b001010;
    localparam logic [5:0] OP_NOT = 6'b001011;
    localparam logic [5:0] OP_SHL = 6'b001100;
    localparam logic [5:0] OP_SHR = 6'b001101;
    localparam logic [5:0] OP_CMP = 6'b001110;
    localparam logic [5:0] OP_INC = 6'b001111;

    // Writeback class of an opcode
    typedef enum logic [1:0] {
        CLS_WB1  = 2'd0,
        CLS_WB2  = 2'd1,
        CLS_NOWB = 2'd2,
        CLS_ILL  = 2'd3
    } op_class_t;

    // Commit FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR_LO = 2'd1,
        ST_WR_HI = 2'd2
    } wb_state_t;

    // True for classes that produce at least one register-file write
    function automatic logic is_write_class(input op_class_t cls);
        return (cls == CLS_WB1) || (cls == CLS_WB2);
    endfunction

endpackage

// File: rtl/wb_opclass.sv
// Maps a 6-bit opcode to its writeback class; shared with hazard logic.
// Latency: purely combinational.
// Backpressure: none.
module wb_opclass
    import alu_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_t  op_class
);

    // Classify: WB2 for mul/div, NOWB for memory transfers, ILL above the defined range
    always_comb begin
        op_class = CLS_ILL;
        if (opcode[5:4] == 2'b00) begin
            case (opcode)
                OP_MUL, OP_DIV:        op_class = CLS_WB2;
                OP_LD, OP_ST, OP_XFR:  op_class = CLS_NOWB;
                default:               op_class = CLS_WB1;
            endcase
        end
    end

endmodule

// File: rtl/alu_writeback.sv
// Commits ALU results to the register file: one byte write, or two for mul/div.
// Latency: low byte 1 cycle after acceptance, high byte 2 cycles after.
// Backpressure: in_ready low while a wide write is in flight (WR_LO of WB2, WR_HI).
module alu_writeback
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    input  logic [15:0]      out,
    output logic             rf_we,
    output logic [4:0]       rf_addr,
    output logic [7:0]       rf_wdata,
    output logic             zero,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    wb_state_t  state, state_nxt;
    op_class_t  new_cls;
    op_class_t  held_cls;
    logic [4:0] held_rdst;
    logic [15:0] held_out;
    logic       accept;

    wb_opclass u_opclass (
        .opcode   (instruction[OPC_MSB:OPC_LSB]),
        .op_class (new_cls)
    );

    // Ready depends on state only, so upstream can never form a comb loop through us
    assign in_ready = (state == ST_IDLE) || (state == ST_WR_LO && held_cls == CLS_WB1);
    assign accept   = in_valid && in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state and register-file write port
    always_comb begin
        state_nxt = state;
        rf_we     = 1'b0;
        rf_addr   = 5'd0;
        rf_wdata  = 8'd0;
        case (state)
            ST_IDLE: begin
                if (accept && is_write_class(new_cls)) state_nxt = ST_WR_LO;
            end
            ST_WR_LO: begin
                rf_we    = 1'b1;
                rf_addr  = held_rdst;
                rf_wdata = held_out[7:0];
                if (held_cls == CLS_WB2)                       state_nxt = ST_WR_HI;
                else if (accept && is_write_class(new_cls))    state_nxt = ST_WR_LO;
                else                                           state_nxt = ST_IDLE;
            end
            ST_WR_HI: begin
                rf_we     = 1'b1;
                rf_addr   = held_rdst + 5'd1;
                rf_wdata  = held_out[15:8];
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Holding registers: capture the accepted op; in WR_LO the old op is already on the port
    always_ff @(posedge clk) begin
        if (!reset) begin
            held_cls  <= CLS_WB1;
            held_rdst <= 5'd0;
            held_out  <= 16'd0;
        end else if (accept) begin
            held_cls  <= new_cls;
            held_rdst <= instruction[RDST_MSB:RDST_LSB];
            held_out  <= out;
        end
    end

    // Status: zero follows the committed (held) result, retired/illegal follow acceptances
    always_ff @(posedge clk) begin
        if (!reset) begin
            zero    <= 1'b0;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            if (state == ST_WR_LO) begin
                if (held_cls == CLS_WB2) zero <= (held_out == 16'd0);
                else                     zero <= (held_out[7:0] == 8'd0);
            end
            if (accept) begin
                retired <= retired + CNT_W'(1);
                if (new_cls == CLS_ILL) illegal <= 1'b1;
            end
        end
    end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Result-commit stage that sits directly downstream of the ALU. It accepts one instruction and its 16-bit ALU result per handshake, classifies the opcode, and drives the register-file write port. Wide results from multiply and divide are committed as two byte writes over two cycles; all other results are committed as a single byte write. It also keeps a retired-instruction counter, a zero flag and a sticky illegal-opcode flag for the control/debug path.

## Interface
Parameters:
- `CNT_W`, 16, width of the retired-instruction counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low; sampled on the rising edge of `clk`.
- `in_valid`  in  1  instruction/result pair is presented.
- `in_ready`  out  1  stage can accept this cycle.
- `instruction`  in  32  `[31:26]` is the opcode; `[25:21]` is the destination register `rdst`.
- `out`  in  16  ALU result; `[7:0]` is the low byte (`out1`), `[15:8]` is the high byte (`out2`).
- `rf_we`  out  1  register-file write strobe.
- `rf_addr`  out  5  register-file write address.
- `rf_wdata`  out  8  register-file write data.
- `zero`  out  1  set when the last committed result was zero.
- `illegal`  out  1  sticky; at least one illegal opcode has been accepted.
- `retired`  out  CNT_W  count of accepted instructions.

## Operation
- **Opcode classes:**
  - WB1, single write of `out[7:0]` to `rdst`: 000000 and 000100–000110, plus 001001–001111.
  - WB2, low byte to `rdst` and high byte to `(rdst+1) mod 32`: 000111 (mul) and 001000 (div). For div the high byte is the remainder.
  - NOWB, accepted with no write: 000001–000011, the memory-transfer ops handled by the storage block.
  - ILL, accepted with no write and `illegal` set: 010000–111111.
- **Capture:** on acceptance, latch the opcode class, `rdst` and `out` into holding registers.
- **State machine:**
  - IDLE → WR_LO on accepting a WB1 or WB2 instruction.
  - IDLE → IDLE on accepting NOWB or ILL.
  - WR_LO → WR_HI when the held op is WB2.
  - WR_LO → WR_LO when the held op is WB1 and a new WB1/WB2 is accepted in the same cycle.
  - WR_LO → IDLE otherwise.
  - WR_HI → IDLE.
- **Write port:**
  - In WR_LO: `rf_we`=1, `rf_addr`=held `rdst`, `rf_wdata`=held `out[7:0]`.
  - In WR_HI: `rf_we`=1, `rf_addr`=held `rdst`+1 (5-bit wrap, so 31 → 0), `rf_wdata`=held `out[15:8]`.
  - In IDLE: `rf_we`=0 and `rf_addr`/`rf_wdata`=0.
- **`in_ready`:** equals `(state==IDLE) || (state==WR_LO && held class==WB1)`. It is combinational from state only and never depends on `in_valid`.
- **`zero`:** updated at the WR_LO write only.
  - WB1: becomes `held out[7:0]==0`.
  - WB2: becomes `held out[15:0]==0`.
  - NOWB/ILL leave it unchanged.
- **`retired`:** increments by 1 on every accepted handshake, including NOWB and ILL. It wraps modulo 2^CNT_W.
- **`illegal`:** set on acceptance of an ILL op. It is cleared only by reset.

## Timing
- **Reset values (`reset`=0 at an edge):**
  - state=IDLE.
  - `rf_we`=0, `rf_addr`=0, `rf_wdata`=0.
  - `zero`=0, `illegal`=0, `retired`=0.
  - holding registers cleared.
  - `in_ready`=1 from the first cycle after reset.
- **Reset mid-operation:** a pending WR_HI is abandoned and its high byte is not written.
- **Handshake:** a transfer occurs on an edge where `in_valid && in_ready`. `instruction` and `out` must be stable while `in_valid`=1. The upstream stage may hold `in_valid` across cycles with `in_ready`=0; no transfer occurs in those cycles.
- **Latency:**
  - The WB1/WB2 low-byte write appears one cycle after acceptance.
  - The WB2 high-byte write appears two cycles after acceptance.
- **Throughput:**
  - Back-to-back WB1 sustains 1 instruction/cycle.
  - A WB2 blocks acceptance during WR_LO and WR_HI, giving 1 instruction per 3 cycles after it.
  - NOWB/ILL accepted in IDLE sustain 1/cycle.
- **Simultaneous events:**
  - Acceptance in WR_LO: the held write is driven this cycle and the new op is captured at the same edge.
  - `zero` reflects the held op.
  - `retired` counts the new op.

## Structure
- **Shared package `alu_pkg`:**
  - opcode constants for all 16 defined opcodes.
  - class encoding WB1/WB2/NOWB/ILL (2 bits).
  - field positions `OPC_MSB`=31, `OPC_LSB`=26, `RDST_MSB`=25, `RDST_LSB`=21.
  - FSM state encoding IDLE/WR_LO/WR_HI.
- **Sub-module `wb_opclass`:** combinational, maps a 6-bit opcode to its 2-bit class; it is reused later by hazard logic.
- **Top level:** FSM, holding registers, counter and flags.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with `in_valid`=1 and opcode 000100 → no `rf_we`, `retired`=0, `in_ready`=1 after release.
- **Single write:** add (000100), `rdst`=5, `out`=16'h0037 → one cycle later `rf_we`=1, `rf_addr`=5, `rf_wdata`=8'h37; `zero`=0; `retired`=1.
- **Wide write with wrap:** mul (000111), `rdst`=31, `out`=16'h1234 → writes (31, 8'h34) then (0, 8'h12) on consecutive cycles; `in_ready`=0 for those 2 cycles.
- **Back-to-back WB1:** 4 WB1 ops to `rdst`=1..4 with `in_valid` held high → 4 writes on 4 consecutive cycles; `in_ready` stays 1. A final sub with `out`=0 → `zero`=1.
- **NOWB then ILL:** opcode 000010 then opcode 110000 → no `rf_we` for either, `illegal`=1 and stays 1, `retired`=2.
- **Reset during WR_LO of a div:** div (001000), `out`=16'h0503, `rdst`=7, reset asserted in the WR_LO cycle → the high-byte write to 8 never occurs; all outputs return to reset values.
